// File: rtl/vsim_clock_reset_seq.sv
// vsim_clock_reset_seq
// Clock/reset sequencer for the VsimTop simulation harness. From one free-running
// CLK it produces the primary reset, a divided derived clock and a delayed
// derived-domain reset. It also tracks run length and ends the run through a
// sticky done flag.
//
// Optional watchdog: define VSIM_TIMEOUT_EN to end the run after TIMEOUT_CYCLES
// cycles in S_RUN. Without the macro, timeout is tied low and the run ends only
// on stop_req.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_RESET | waiting for the synchronised primary reset to release
// S_HOLD  | counting derived-clock rises before releasing the derived reset
// S_RUN   | harness running; cycle_count advances every CLK edge
// S_DONE  | terminal; outputs frozen, derived clock parked low
`timescale 1ns/1ps

module vsim_clock_reset_seq #(
    parameter int DIV_RATIO       = 4,
    parameter int RST_HOLD_CYCLES = 5,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stop_req,
    output logic             nRST_out,
    output logic             CLK_derivedClock,
    output logic             nRST_derivedReset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int HALF   = DIV_RATIO / 2;
    localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
`ifdef VSIM_TIMEOUT_EN
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]        state;
    logic              rstSync;
    logic [DIV_W-1:0]  divCnt;
    logic [HOLD_W-1:0] holdCnt;
    logic              divRun;
    logic              divWrap;
    logic              derivedRise;

    // Once done, the divider only keeps going to complete a high phase, so the
    // derived clock never shows a runt pulse and then stays parked low.
    assign divRun      = nRST_out && ((state != S_DONE) || CLK_derivedClock);
    assign divWrap     = divRun && (divCnt == DIV_LAST);
    assign derivedRise = divWrap && !CLK_derivedClock;

    // Two-flop synchroniser: assert immediately, release on the 2nd CLK edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rstSync  <= 1'b0;
            nRST_out <= 1'b0;
        end else begin
            rstSync  <= 1'b1;
            nRST_out <= rstSync;
        end
    end

    // Half-period counter; the derived clock toggles each time it wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            divCnt           <= '0;
            CLK_derivedClock <= 1'b0;
        end else if (divRun) begin
            if (divWrap) begin
                divCnt           <= '0;
                CLK_derivedClock <= ~CLK_derivedClock;
            end else begin
                divCnt <= divCnt + 1'b1;
            end
        end
    end

    // Sequencing FSM: hold count, derived-reset release, run-length tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= S_RESET;
            holdCnt           <= '0;
            nRST_derivedReset <= 1'b0;
            running           <= 1'b0;
            done              <= 1'b0;
            cycle_count       <= '0;
`ifdef VSIM_TIMEOUT_EN
            timeout           <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    if (nRST_out) begin
                        state   <= S_HOLD;
                        holdCnt <= HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    // holdCnt is a down-counter; terminal count 0 marks the last rise.
                    if (derivedRise) begin
                        if (holdCnt == '0) begin
                            state             <= S_RUN;
                            nRST_derivedReset <= 1'b1;
                            running           <= 1'b1;
                        end else begin
                            holdCnt <= holdCnt - 1'b1;
                        end
                    end
                end
                S_RUN: begin
`ifdef VSIM_TIMEOUT_EN
                    if (cycle_count == TO_LAST) begin
                        // A coincident stop_req wins the count: no increment.
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        running <= 1'b0;
                        if (!stop_req && (cycle_count != CNT_MAX)) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end else
`endif
                    if (stop_req) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        running <= 1'b0;
                    end else if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

`ifndef VSIM_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vsim_clock_reset_seq.sv
// Bench for vsim_clock_reset_seq: table-driven startup sequence checked via a
// scoreboard queue, plus hand-written stop, timeout, async-reset and saturation runs.
`timescale 1ns/1ps

module tb_vsim_clock_reset_seq;

    typedef struct {
        logic        rst;
        logic        stop;
        logic        nRst;
        logic        dclk;
        logic        nRstD;
        logic        run;
        logic        dn;
        logic [31:0] cnt;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        stopReq;
    logic        nRstOut, dClk, nRstD, running, done, timeout;
    logic [31:0] cycleCount;

    logic        stop2;
    logic        nRstOut2, dClk2, nRstD2, running2, done2, timeout2;
    logic [3:0]  cycleCount2;

    int   nVec  = 0;
    int   nMiss = 0;
    vec_t tbl[25];
    vec_t expQ[$];
    vec_t ce;

    vsim_clock_reset_seq #(
        .DIV_RATIO(4), .RST_HOLD_CYCLES(5), .TIMEOUT_CYCLES(50), .CNT_W(32)
    ) dut (
        .CLK(CLK), .RST(RST), .stop_req(stopReq),
        .nRST_out(nRstOut), .CLK_derivedClock(dClk), .nRST_derivedReset(nRstD),
        .running(running), .done(done), .timeout(timeout), .cycle_count(cycleCount)
    );

    // Small counter instance to reach saturation / watchdog quickly.
    vsim_clock_reset_seq #(
        .DIV_RATIO(4), .RST_HOLD_CYCLES(1), .TIMEOUT_CYCLES(10), .CNT_W(4)
    ) dut2 (
        .CLK(CLK), .RST(RST), .stop_req(stop2),
        .nRST_out(nRstOut2), .CLK_derivedClock(dClk2), .nRST_derivedReset(nRstD2),
        .running(running2), .done(done2), .timeout(timeout2), .cycle_count(cycleCount2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk1(input string nm, input logic act, input logic exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkN(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: pop one expected record per CLK edge, compare just after it.
    always @(posedge CLK) begin
        #1;
        if (expQ.size() != 0) begin
            ce = expQ.pop_front();
            chk1("sb nRST_out", nRstOut, ce.nRst);
            chk1("sb derivedClock", dClk, ce.dclk);
            chk1("sb nRST_derivedReset", nRstD, ce.nRstD);
            chk1("sb running", running, ce.run);
            chk1("sb done", done, ce.dn);
            chk1("sb timeout", timeout, 1'b0);
            chkN("sb cycle_count", cycleCount, ce.cnt);
        end
    end

    // Expected startup timeline: 3 reset cycles then edges 1..22 after release.
    task automatic fillTable();
        for (int i = 0; i < 3; i++) begin
            tbl[i] = '{rst: 1'b1, stop: 1'b0, nRst: 1'b0, dclk: 1'b0,
                       nRstD: 1'b0, run: 1'b0, dn: 1'b0, cnt: 32'd0};
        end
        for (int e = 1; e <= 22; e++) begin
            tbl[e + 2].rst   = 1'b0;
            tbl[e + 2].stop  = 1'b0;
            tbl[e + 2].nRst  = (e >= 2);
            tbl[e + 2].dclk  = (e >= 4) && (((e - 4) % 4) < 2);
            tbl[e + 2].nRstD = (e >= 20);
            tbl[e + 2].run   = (e >= 20);
            tbl[e + 2].dn    = 1'b0;
            tbl[e + 2].cnt   = (e >= 20) ? 32'(e - 20) : 32'd0;
        end
    endtask

    task automatic runTable();
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            RST     = tbl[i].rst;
            stopReq = tbl[i].stop;
            expQ.push_back(tbl[i]);
        end
        @(posedge CLK);
        #2;
    endtask

    task automatic waitCount(input logic [31:0] target, input int maxCyc);
        int n;
        n = 0;
        while ((cycleCount !== target) && (n < maxCyc)) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (cycleCount !== target) chkN("waitCount bound", cycleCount, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        RST     = 1'b1;
        stopReq = 1'b0;
        stop2   = 1'b0;
        fillTable();

        // Startup: reset release, derived clock, hold count, run start.
        runTable();

        // Async reset in the middle of S_RUN, then the identical startup again.
        waitCount(32'd37, 200);
        #2;
        RST = 1'b1;
        #1;
        chk1("async nRST_out", nRstOut, 1'b0);
        chk1("async derivedClock", dClk, 1'b0);
        chk1("async nRST_derivedReset", nRstD, 1'b0);
        chk1("async running", running, 1'b0);
        chk1("async done", done, 1'b0);
        chk1("async timeout", timeout, 1'b0);
        chkN("async cycle_count", cycleCount, 32'd0);
        runTable();

`ifdef VSIM_TIMEOUT_EN
        // Watchdog with no stop_req.
        waitCount(32'd49, 200);
        @(posedge CLK); #1;
        chkN("to cycle_count", cycleCount, 32'd50);
        chk1("to done", done, 1'b1);
        chk1("to timeout", timeout, 1'b1);
        chk1("to running", running, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chkN("to hold count", cycleCount, 32'd50);
        chk1("to hold done", done, 1'b1);

        // Watchdog and stop_req on the same edge: no increment.
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        waitCount(32'd49, 200);
        stopReq = 1'b1;
        @(posedge CLK); #1;
        stopReq = 1'b0;
        chkN("to+stop cycle_count", cycleCount, 32'd49);
        chk1("to+stop done", done, 1'b1);
        chk1("to+stop timeout", timeout, 1'b1);
`else
        // stop_req pulse at count 100; derived clock finishes its high phase.
        waitCount(32'd100, 200);
        chk1("pre-stop derivedClock", dClk, 1'b1);
        stopReq = 1'b1;
        @(posedge CLK); #1;
        stopReq = 1'b0;
        chk1("stop done", done, 1'b1);
        chk1("stop running", running, 1'b0);
        chkN("stop cycle_count", cycleCount, 32'd100);
        chk1("stop timeout", timeout, 1'b0);
        chk1("stop derivedClock high", dClk, 1'b1);
        @(posedge CLK); #1;
        chk1("stop derivedClock fall", dClk, 1'b0);
        repeat (8) @(posedge CLK);
        #1;
        chk1("parked derivedClock", dClk, 1'b0);
        chkN("parked cycle_count", cycleCount, 32'd100);
        chk1("parked done", done, 1'b1);
        chk1("parked nRST_derivedReset", nRstD, 1'b1);
`endif

        // stop_req held through reset/hold: honoured on the first S_RUN edge.
        @(negedge CLK); RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST     = 1'b0;
        stopReq = 1'b1;
        n = 0;
        while ((done !== 1'b1) && (n < 100)) begin
            @(posedge CLK);
            #1;
            n++;
            if ((n == 20) && (running !== 1'b1)) chk1("held-stop running@20", running, 1'b1);
        end
        chkN("held-stop done edge", 32'(n), 32'd21);
        chkN("held-stop cycle_count", cycleCount, 32'd0);
        chk1("held-stop running", running, 1'b0);
        chk1("held-stop timeout", timeout, 1'b0);
        stopReq = 1'b0;

        // Small-counter instance: saturation (or watchdog when enabled).
        repeat (40) @(posedge CLK);
        #1;
`ifdef VSIM_TIMEOUT_EN
        chkN("dut2 cycle_count", 32'(cycleCount2), 32'd10);
        chk1("dut2 done", done2, 1'b1);
        chk1("dut2 timeout", timeout2, 1'b1);
`else
        chkN("dut2 saturated count", 32'(cycleCount2), 32'd15);
        chk1("dut2 done", done2, 1'b0);
        chk1("dut2 running", running2, 1'b1);
        chk1("dut2 timeout", timeout2, 1'b0);
`endif
        chkN("held-stop count frozen", cycleCount, 32'd0);
        chk1("held-stop done sticky", done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
